// File: rtl/link_frame_sequencer_pkg.sv
// Shared defaults and FSM state type for the link frame sequencer.
// Kept as a package so the top and the bench agree on widths and encodings.
package link_frame_sequencer_pkg;

  localparam int unsigned LFS_FRAME_W     = 28;
  localparam int unsigned LFS_SYM_W       = 2;
  localparam int unsigned LFS_PIPE_LAT    = 3;
  localparam int unsigned LFS_ILV_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ILV = 2'd1,
    ST_TX       = 2'd2,
    ST_DRAIN    = 2'd3
  } lfs_state_e;

endpackage

// File: rtl/link_frame_sequencer_valid_delay.sv
// valid_delay_line: DEPTH-cycle delay of a 1-bit valid strobe, async active-low clear.
// DEPTH=0 degenerates to a wire.
module valid_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic valid_o
);

  if (DEPTH == 0) begin : g_bypass
    assign valid_o = valid_i;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
      sr_d    = sr_q << 1;
      sr_d[0] = valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
    end

    assign valid_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/link_frame_sequencer.sv
// Frame-level controller: enables the interleaver, serialises the masked frame into
// symbols, re-assembles the demodulated symbols after the pipeline latency, enables the deinterleaver.
module link_frame_sequencer
  import link_frame_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_W     = LFS_FRAME_W,
  parameter int unsigned SYM_W       = LFS_SYM_W,
  parameter int unsigned PIPE_LAT    = LFS_PIPE_LAT,
  parameter int unsigned ILV_TIMEOUT = LFS_ILV_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] err_mask_i,
  output logic               inter_en_o,
  input  logic               frame_valid_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic [SYM_W-1:0]   sym_o,
  output logic               sym_valid_o,
  input  logic [SYM_W-1:0]   sym_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               deinter_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [7:0]         frame_cnt_o
);

  localparam int unsigned N_SYM  = FRAME_W / SYM_W;
  localparam int unsigned IDX_W  = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int unsigned WCNT_W = $clog2(ILV_TIMEOUT + 1);

  lfs_state_e         state_q, state_d;
  logic [FRAME_W-1:0] mask_q, mask_d;
  logic [FRAME_W-1:0] tx_frame_q, tx_frame_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
  logic [IDX_W-1:0]   rx_idx_q, rx_idx_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               inter_en_q, inter_en_d;
  logic               deinter_en_q, deinter_en_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               rx_valid;
  logic               rx_last;

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_valid_dly (
    .clk     (clk),
    .rst_n   (rst),
    .valid_i (sym_valid_o),
    .valid_o (rx_valid)
  );

  assign sym_valid_o = (state_q == ST_TX);
  assign sym_o       = sym_valid_o ? tx_frame_q[SYM_W*tx_idx_q +: SYM_W] : '0;
  assign rx_last     = rx_valid && (rx_idx_q == IDX_W'(N_SYM - 1));

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    tx_frame_d   = tx_frame_q;
    frame_d      = frame_q;
    tx_idx_d     = tx_idx_q;
    rx_idx_d     = rx_idx_q;
    wait_cnt_d   = wait_cnt_q;
    inter_en_d   = inter_en_q;
    deinter_en_d = deinter_en_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;

    // Receive side tracks the delayed valid only; completion flags land together
    // so done_o, deinter_en_o and the count all appear in the same cycle.
    if (rx_valid) begin
      frame_d[SYM_W*rx_idx_q +: SYM_W] = sym_i;
      rx_idx_d = rx_last ? '0 : rx_idx_q + 1'b1;
    end
    if (rx_last) begin
      deinter_en_d = 1'b1;
      done_d       = 1'b1;
      frame_cnt_d  = frame_cnt_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d       = err_mask_i;
          deinter_en_d = 1'b0;
          inter_en_d   = 1'b1;
          wait_cnt_d   = '0;
          state_d      = ST_WAIT_ILV;
        end
      end
      ST_WAIT_ILV: begin
        if (frame_valid_i) begin
          tx_frame_d = frame_i ^ mask_q;
          inter_en_d = 1'b0;
          tx_idx_d   = '0;
          state_d    = ST_TX;
        end else if (wait_cnt_q == WCNT_W'(ILV_TIMEOUT - 1)) begin
          inter_en_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_TX: begin
        if (tx_idx_q == IDX_W'(N_SYM - 1)) state_d = ST_DRAIN;
        else                               tx_idx_d = tx_idx_q + 1'b1;
      end
      // Stay busy through the done cycle so a start there is not accepted.
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      tx_frame_q   <= '0;
      frame_q      <= '0;
      tx_idx_q     <= '0;
      rx_idx_q     <= '0;
      wait_cnt_q   <= '0;
      inter_en_q   <= 1'b0;
      deinter_en_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      tx_frame_q   <= tx_frame_d;
      frame_q      <= frame_d;
      tx_idx_q     <= tx_idx_d;
      rx_idx_q     <= rx_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      inter_en_q   <= inter_en_d;
      deinter_en_q <= deinter_en_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign inter_en_o   = inter_en_q;
  assign deinter_en_o = deinter_en_q;
  assign frame_o      = frame_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule
